// File: rtl/uop_station.sv
// uop_station: in-order micro-op queue between decode and execute, with a per-group operand override.
// Latency: one cycle from push to ex_uop_valid (no bypass); head outputs are combinational from state.
// Backpressure: id_feed_req drops when fewer than 3 entries are free; UOP_STATION_FLUSH_EN adds ex_flush.
module uop_station #(
  parameter int               UOP_W  = 20,
  parameter int               DATA_W = 16,
  parameter int               DEPTH  = 8,
  parameter logic [UOP_W-1:0] NOP    = 20'h00F00
) (
  input  logic              clk,
  input  logic              a_rst,
`ifdef UOP_STATION_FLUSH_EN
  input  logic              ex_flush,
`endif
  input  logic [UOP_W-1:0]  id_uop_0,
  input  logic [UOP_W-1:0]  id_uop_1,
  input  logic [UOP_W-1:0]  id_uop_2,
  input  logic [1:0]        id_uop_count,
  input  logic [DATA_W-1:0] id_k16,
  output logic              id_feed_req,
  output logic [UOP_W-1:0]  ex_uop_next,
  output logic              ex_uop_valid,
  output logic              ex_group_end,
  input  logic              ex_sched_ack,
  output logic [UOP_W-1:0]  ex_uop_last,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_wr,
  output logic [DATA_W-1:0] ex_data_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage is never reset: occupancy alone decides what is valid.
  logic [UOP_W-1:0]  uop_mem_q [DEPTH];
  logic [DATA_W-1:0] k16_mem_q [DEPTH];
  logic              end_mem_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              own_q, own_d;
  logic [DATA_W-1:0] ovr_q, ovr_d;
  logic [UOP_W-1:0]  last_q, last_d;

  logic              flush;
  logic              empty;
  logic              pop;
  logic              ovr_wr;
  logic [1:0]        push_n;
  logic [UOP_W-1:0]  slot_uop [3];

`ifdef UOP_STATION_FLUSH_EN
  assign flush = ex_flush;
`else
  assign flush = 1'b0;
`endif

  // Accept/consume decisions and head presentation, all from current state.
  always_comb begin
    empty        = (count_q == '0);
    id_feed_req  = (CNT_W'(DEPTH) - count_q) >= CNT_W'(3);
    push_n       = (id_feed_req && !flush) ? id_uop_count : 2'd0;
    pop          = ex_sched_ack && !empty && !flush;
    ovr_wr       = mem_data_wr && !empty && !flush;
    slot_uop[0]  = id_uop_0;
    slot_uop[1]  = id_uop_1;
    slot_uop[2]  = id_uop_2;
    ex_uop_valid = !empty;
    ex_uop_next  = empty ? NOP : uop_mem_q[rd_ptr_q];
    ex_group_end = empty ? 1'b0 : end_mem_q[rd_ptr_q];
    ex_uop_last  = last_q;
    if (own_q) begin
      ex_data_out = ovr_q;
    end else if (!empty) begin
      ex_data_out = k16_mem_q[rd_ptr_q];
    end else begin
      ex_data_out = '0;
    end
  end

  // Next-state: pointers, occupancy, override ownership and last-consumed uop.
  always_comb begin
    rd_ptr_d = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));
    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    count_d  = count_q + CNT_W'(push_n) - (pop ? CNT_W'(1) : CNT_W'(0));
    own_d    = own_q;
    ovr_d    = ovr_q;
    last_d   = pop ? uop_mem_q[rd_ptr_q] : last_q;
    // Leaving a group drops the override, even against a same-edge write.
    if (pop && end_mem_q[rd_ptr_q]) begin
      own_d = 1'b0;
    end else if (ovr_wr) begin
      own_d = 1'b1;
      ovr_d = mem_data_in;
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      own_d    = 1'b0;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      own_q    <= 1'b0;
      ovr_q    <= '0;
      last_q   <= NOP;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      own_q    <= own_d;
      ovr_q    <= ovr_d;
      last_q   <= last_d;
    end
  end

  // Group write: up to three consecutive entries, end flag on the last one only.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (i < int'(push_n)) begin
        uop_mem_q[wr_ptr_q + PTR_W'(i)] <= slot_uop[i];
        k16_mem_q[wr_ptr_q + PTR_W'(i)] <= id_k16;
        end_mem_q[wr_ptr_q + PTR_W'(i)] <= (i == int'(push_n) - 1);
      end
    end
  end

endmodule

// File: tb/tb_uop_station.sv
// tb_uop_station: directed stimulus for uop_station, checked every cycle against a queue-based model
// plus literal expectations at the points of interest (group order, full, wrap, override, empty, flush, reset).
// Inputs change 1 time unit after the rising edge; the model steps on the rising edge, compares on the falling.
module tb_uop_station;

  localparam int          UW    = 20;
  localparam int          DW    = 16;
  localparam int          DEPTH = 8;
  localparam logic [19:0] NOP   = 20'h00F00;

  logic          clk = 1'b0;
  logic          a_rst;
  logic [UW-1:0] id_uop_0, id_uop_1, id_uop_2;
  logic [1:0]    id_uop_count;
  logic [DW-1:0] id_k16;
  logic          id_feed_req;
  logic [UW-1:0] ex_uop_next;
  logic          ex_uop_valid;
  logic          ex_group_end;
  logic          ex_sched_ack;
  logic [UW-1:0] ex_uop_last;
  logic [DW-1:0] mem_data_in;
  logic          mem_data_wr;
  logic [DW-1:0] ex_data_out;
`ifdef UOP_STATION_FLUSH_EN
  logic          ex_flush = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uop_station #(.UOP_W(UW), .DATA_W(DW), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
`ifdef UOP_STATION_FLUSH_EN
    .ex_flush     (ex_flush),
`endif
    .id_uop_0     (id_uop_0),
    .id_uop_1     (id_uop_1),
    .id_uop_2     (id_uop_2),
    .id_uop_count (id_uop_count),
    .id_k16       (id_k16),
    .id_feed_req  (id_feed_req),
    .ex_uop_next  (ex_uop_next),
    .ex_uop_valid (ex_uop_valid),
    .ex_group_end (ex_group_end),
    .ex_sched_ack (ex_sched_ack),
    .ex_uop_last  (ex_uop_last),
    .mem_data_in  (mem_data_in),
    .mem_data_wr  (mem_data_wr),
    .ex_data_out  (ex_data_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [UW-1:0] uop;
    logic [DW-1:0] k;
    logic          e;
  } ent_t;

  ent_t          mq[$];
  logic          m_own = 1'b0;
  logic [DW-1:0] m_ovr = '0;
  logic [UW-1:0] m_last = NOP;
  ent_t          m_head;
  logic [UW-1:0] m_in[3];
  bit            m_room, m_took, m_flush;

  always @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      mq.delete();
      m_own  = 1'b0;
      m_ovr  = '0;
      m_last = NOP;
    end else begin
      m_flush = 1'b0;
`ifdef UOP_STATION_FLUSH_EN
      m_flush = ex_flush;
`endif
      m_room  = (DEPTH - mq.size()) >= 3;
      m_in[0] = id_uop_0;
      m_in[1] = id_uop_1;
      m_in[2] = id_uop_2;
      if (m_flush) begin
        mq.delete();
        m_own = 1'b0;
      end else begin
        m_took = ex_sched_ack && (mq.size() != 0);
        m_head = '0;
        if (m_took) begin
          m_head = mq.pop_front();
          m_last = m_head.uop;
        end
        if (m_took && m_head.e) begin
          m_own = 1'b0;
        end else if (mem_data_wr && (m_took || mq.size() != 0)) begin
          m_own = 1'b1;
          m_ovr = mem_data_in;
        end
        if (m_room) begin
          for (int i = 0; i < int'(id_uop_count); i++)
            mq.push_back('{uop: m_in[i], k: id_k16, e: (i == int'(id_uop_count) - 1)});
        end
      end
    end
  end

  // One compare process: every cycle out of reset, all outputs against the model.
  always @(negedge clk) begin
    if (a_rst === 1'b1) begin
      chk("valid", 32'(ex_uop_valid), 32'(mq.size() != 0));
      chk("next",  32'(ex_uop_next),  32'((mq.size() != 0) ? mq[0].uop : NOP));
      chk("gend",  32'(ex_group_end), 32'((mq.size() != 0) ? mq[0].e : 1'b0));
      chk("data",  32'(ex_data_out),  32'(m_own ? m_ovr : ((mq.size() != 0) ? mq[0].k : 16'h0)));
      chk("feed",  32'(id_feed_req),  32'((DEPTH - mq.size()) >= 3));
      chk("last",  32'(ex_uop_last),  32'(m_last));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_uop_0 = '0; id_uop_1 = '0; id_uop_2 = '0; id_uop_count = 2'd0; id_k16 = '0;
    ex_sched_ack = 1'b0; mem_data_wr = 1'b0; mem_data_in = '0;
  endtask

  task automatic cyc(input logic [1:0] cnt, input logic [19:0] a, input logic [19:0] b,
                     input logic [19:0] c, input logic [15:0] k, input logic ack,
                     input logic wr, input logic [15:0] wd);
    id_uop_0 = a; id_uop_1 = b; id_uop_2 = c; id_uop_count = cnt; id_k16 = k;
    ex_sched_ack = ack; mem_data_wr = wr; mem_data_in = wd;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [1:0] cnt, input logic [19:0] a, input logic [19:0] b,
                      input logic [19:0] c, input logic [15:0] k);
    cyc(cnt, a, b, c, k, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic ack();
    cyc(2'd0, 20'h0, 20'h0, 20'h0, 16'h0, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(ex_uop_valid), 32'h0);
    chk({tag, "_next"},  32'(ex_uop_next),  32'h00F00);
    chk({tag, "_gend"},  32'(ex_group_end), 32'h0);
    chk({tag, "_data"},  32'(ex_data_out),  32'h0);
    chk({tag, "_feed"},  32'(id_feed_req),  32'h1);
    chk({tag, "_last"},  32'(ex_uop_last),  32'h00F00);
  endtask

  initial begin
    a_rst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    a_rst = 1'b1;
    @(posedge clk);
    #1;

    // Group A,B,C with k16 1234: one-cycle latency, end flag on C only.
    push(2'd3, 20'h0000A, 20'h0000B, 20'h0000C, 16'h1234);
    chk("g_next_A", 32'(ex_uop_next),  32'h0000A);
    chk("g_data",   32'(ex_data_out),  32'h1234);
    chk("g_gend_A", 32'(ex_group_end), 32'h0);
    ack();
    ack();
    chk("g_next_C", 32'(ex_uop_next),  32'h0000C);
    chk("g_gend_C", 32'(ex_group_end), 32'h1);
    chk("g_last_B", 32'(ex_uop_last),  32'h0000B);
    ack();
    chk("g_empty",  32'(ex_uop_valid), 32'h0);
    chk("g_last_C", 32'(ex_uop_last),  32'h0000C);

    // Fill: 3 + 3 leaves 2 free, so the 2-group is refused.
    push(2'd3, 20'h00011, 20'h00012, 20'h00013, 16'h1111);
    chk("f_feed3", 32'(id_feed_req), 32'h1);
    push(2'd3, 20'h00021, 20'h00022, 20'h00023, 16'h2222);
    chk("f_feed6", 32'(id_feed_req), 32'h0);
    push(2'd2, 20'h00031, 20'h00032, 20'h0, 16'h3333);
    chk("f_feed6b", 32'(id_feed_req), 32'h0);
    chk("f_head",   32'(ex_uop_next), 32'h00011);
    for (int i = 0; i < 6; i++) ack();
    chk("f_drained", 32'(ex_uop_valid), 32'h0);
    chk("f_last",    32'(ex_uop_last),  32'h00023);

    // Count 5, then push-1 with ack on three edges; write pointer crosses 7 -> 0.
    push(2'd3, 20'h00041, 20'h00042, 20'h00043, 16'h4444);
    push(2'd2, 20'h00051, 20'h00052, 20'h0, 16'h5555);
    chk("w_feed5", 32'(id_feed_req), 32'h1);
    cyc(2'd1, 20'h00061, 20'h0, 20'h0, 16'h6161, 1'b1, 1'b0, 16'h0);
    chk("w_last41", 32'(ex_uop_last), 32'h00041);
    cyc(2'd1, 20'h00062, 20'h0, 20'h0, 16'h6262, 1'b1, 1'b0, 16'h0);
    cyc(2'd1, 20'h00063, 20'h0, 20'h0, 16'h6363, 1'b1, 1'b0, 16'h0);
    chk("w_next51", 32'(ex_uop_next), 32'h00051);
    chk("w_feed",   32'(id_feed_req), 32'h1);
    for (int i = 0; i < 5; i++) ack();
    chk("w_last63", 32'(ex_uop_last),  32'h00063);
    chk("w_empty",  32'(ex_uop_valid), 32'h0);

    // Override mid-group; dropped at the end-flagged pop, even against a same-edge write.
    push(2'd3, 20'h00071, 20'h00072, 20'h00073, 16'hAAAA);
    push(2'd1, 20'h00081, 20'h0, 20'h0, 16'h5555);
    chk("o_k16", 32'(ex_data_out), 32'hAAAA);
    cyc(2'd0, 20'h0, 20'h0, 20'h0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
    chk("o_beef0", 32'(ex_data_out), 32'hBEEF);
    ack();
    chk("o_beef1", 32'(ex_data_out), 32'hBEEF);
    ack();
    chk("o_beef2", 32'(ex_data_out),  32'hBEEF);
    chk("o_gend",  32'(ex_group_end), 32'h1);
    cyc(2'd0, 20'h0, 20'h0, 20'h0, 16'h0, 1'b1, 1'b1, 16'h9999);
    chk("o_next", 32'(ex_data_out), 32'h5555);
    chk("o_head", 32'(ex_uop_next), 32'h00081);
    ack();
    chk("o_empty", 32'(ex_data_out), 32'h0);

    // Ack and override write on an empty station change nothing.
    cyc(2'd0, 20'h0, 20'h0, 20'h0, 16'h0, 1'b1, 1'b1, 16'h1357);
    chk("e_valid", 32'(ex_uop_valid), 32'h0);
    chk("e_next",  32'(ex_uop_next),  32'h00F00);
    chk("e_data",  32'(ex_data_out),  32'h0);
    chk("e_last",  32'(ex_uop_last),  32'h00081);
    push(2'd1, 20'h000A1, 20'h0, 20'h0, 16'h0246);
    chk("e_noown", 32'(ex_data_out), 32'h0246);
    ack();

`ifdef UOP_STATION_FLUSH_EN
    // Flush at count 4 beats the push, pop and override write offered with it.
    push(2'd3, 20'h000B1, 20'h000B2, 20'h000B3, 16'hB0B0);
    push(2'd1, 20'h000B4, 20'h0, 20'h0, 16'hB4B4);
    ex_flush = 1'b1;
    cyc(2'd3, 20'h000C1, 20'h000C2, 20'h000C3, 16'hC0C0, 1'b1, 1'b1, 16'hDEAD);
    ex_flush = 1'b0;
    chk("x_valid", 32'(ex_uop_valid), 32'h0);
    chk("x_feed",  32'(id_feed_req),  32'h1);
    chk("x_last",  32'(ex_uop_last),  32'h000A1);
    push(2'd1, 20'h000D1, 20'h0, 20'h0, 16'h1111);
    chk("x_next", 32'(ex_uop_next), 32'h000D1);
    chk("x_data", 32'(ex_data_out), 32'h1111);
    ack();
`endif

    // Reset mid-group: outputs return to reset values without waiting for an edge.
    push(2'd3, 20'h00091, 20'h00092, 20'h00093, 16'h7777);
    ack();
    chk("r_next92", 32'(ex_uop_next), 32'h00092);
    a_rst = 1'b0;
    #1;
    chk_reset_vals("rst1");
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    push(2'd1, 20'h000E1, 20'h0, 20'h0, 16'h4321);
    chk("r_next", 32'(ex_uop_next), 32'h000E1);
    chk("r_data", 32'(ex_data_out), 32'h4321);
    ack();

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
